reg_value_fwd: RTL and testbench
================================

Name: reg_value_fwd

Overview:
- Operand-bypass (forwarding) selector for a MIPS-style pipeline. Used in the MEM stage to pick the store-data value.
- Returns the register-file value for a source register unless a newer in-flight write to the same register takes priority. In that case it returns the forwarded write data.
- Output path is purely combinational.
- A small clocked block keeps forwarding statistics for debug.

Parameters:
- DATA_W, 32, data width.
- REG_W, 5, register-index width (32 architectural registers).
- CNT_W, 32, width of the forwarding-hit counter.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  reset, asynchronous, active-low.
- ReadRegister1  in  REG_W  index of the source register being read.
- RegisterData1  in  DATA_W  value of ReadRegister1 from the register file or pipeline latch.
- WriteRegister1stPri1  in  REG_W  destination index of the highest-priority in-flight write.
- WriteData1stPri1  in  DATA_W  data of that in-flight write.
- Valid1stPri1  in  1  the in-flight write is real (RegWrite asserted).
- comment  in  1  debug enable. Simulation-only trace when 1; no functional effect.
- Output1  out  DATA_W  selected operand value (combinational).
- fwd_hit  out  1  combinational; 1 when Output1 is taken from WriteData1stPri1.
- fwd_count  out  CNT_W  registered count of cycles with fwd_hit=1.
- fwd_hit_q  out  1  fwd_hit registered on the previous rising CLK.

Behaviour:
- hit = Valid1stPri1 AND (WriteRegister1stPri1 == ReadRegister1) AND (ReadRegister1 != 0).
- Register 0 is hard-wired zero and is never forwarded.
- Output1 = hit ? WriteData1stPri1 : RegisterData1. fwd_hit = hit.
- Output1 and fwd_hit are combinational, zero latency, and independent of CLK and RESET. Output1 is valid even while RESET is asserted.
- When ReadRegister1 == 0, Output1 = RegisterData1 unchanged; the block does not force zero.
- If any input is X, Output1 follows normal Verilog mux semantics. No special handling.
- Clocked state:
  - RESET low (asynchronous) sets fwd_count = 0 and fwd_hit_q = 0 immediately, without waiting for CLK.
  - On rising CLK with RESET high: fwd_hit_q <= hit; fwd_count <= fwd_count + hit.
  - fwd_count saturates at all-ones; it does not wrap.
- RESET released mid-operation: counting resumes on the first rising edge after RESET goes high.
- comment=1: on each rising CLK with hit=1, simulation prints a trace line with the read index and the selected value. Non-synthesizable code must be guarded out of synthesis.
- No handshake; inputs are sampled every cycle.

Decomposition:
- Shared package: DATA_W/REG_W constants and ZERO_REG = 0.
- Optional leaf sub-module fwd_sat_counter for the saturating counter. The top level keeps the compare/mux.
- Multi-source priority chains are built by cascading instances: the output of one stage feeds RegisterData1 of the next, so the highest priority is applied last.

Test Plan:
1. Read=5, RegData=0x11111111, WrReg=5, WrData=0xDEADBEEF, Valid=1 -> Output1=0xDEADBEEF, fwd_hit=1; after one clock fwd_count=1 and fwd_hit_q=1.
2. Same as test 1 but Valid=0 -> Output1=0x11111111, fwd_hit=0, fwd_count unchanged.
3. Read=0, WrReg=0, Valid=1, WrData=0xFFFFFFFF, RegData=0 -> Output1=0, fwd_hit=0.
4. Read=7, WrReg=8, Valid=1 -> Output1=RegisterData1. Then change WrReg to 7 without a clock edge -> Output1=WrData in the same delta cycle.
5. Three hit cycles, then RESET driven low between clock edges -> fwd_count=0 and fwd_hit_q=0 immediately. Output1 still tracks the inputs during reset.
6. With CNT_W=2, five consecutive hit cycles -> fwd_count reads 1, 2, 3, 3, 3 (saturates).

Source files
------------

// File: rtl/reg_value_fwd_pkg.sv
// Shared constants for the MEM-stage store-data forwarding selector.
package reg_value_fwd_pkg;
    localparam int FWD_DATA_W = 32;
    localparam int FWD_REG_W  = 5;
    localparam int FWD_CNT_W  = 32;
    // Register 0 is hard-wired zero and never takes forwarded data
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/reg_value_fwd_if.sv
// Operand/bypass bundle between the pipeline (master) and the forwarding selector (slave).
interface reg_value_fwd_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic [REG_W-1:0]  ReadRegister1;
    logic [DATA_W-1:0] RegisterData1;
    logic [REG_W-1:0]  WriteRegister1stPri1;
    logic [DATA_W-1:0] WriteData1stPri1;
    logic              Valid1stPri1;
    logic [DATA_W-1:0] Output1;
    logic              fwd_hit;

    modport master (
        output ReadRegister1, RegisterData1, WriteRegister1stPri1,
               WriteData1stPri1, Valid1stPri1,
        input  Output1, fwd_hit
    );
    modport slave (
        input  ReadRegister1, RegisterData1, WriteRegister1stPri1,
               WriteData1stPri1, Valid1stPri1,
        output Output1, fwd_hit
    );
endinterface

// File: rtl/reg_value_fwd_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module fwd_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;
endmodule

// File: rtl/reg_value_fwd.sv
// Store-data bypass: picks the in-flight write data over the register value on a
// live, non-zero index match. Cascade instances to build longer priority chains.
module reg_value_fwd
    import reg_value_fwd_pkg::*;
#(
    parameter int DATA_W = FWD_DATA_W,
    parameter int REG_W  = FWD_REG_W,
    parameter int CNT_W  = FWD_CNT_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               comment,
    reg_value_fwd_if.slave     bus,
    output logic [CNT_W-1:0]   fwd_count,
    output logic               fwd_hit_q
);
    logic w_hit;
    logic r_hit_q;

    // Pure combinational path: no dependence on CLK or RESET
    assign w_hit = bus.Valid1stPri1
                && (bus.WriteRegister1stPri1 == bus.ReadRegister1)
                && (bus.ReadRegister1 != REG_W'(ZERO_REG));

    assign bus.Output1 = w_hit ? bus.WriteData1stPri1 : bus.RegisterData1;
    assign bus.fwd_hit = w_hit;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            r_hit_q <= 1'b0;
        else
            r_hit_q <= w_hit;
    end

    assign fwd_hit_q = r_hit_q;

    fwd_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_inc   (w_hit),
        .o_count (fwd_count)
    );

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (comment && w_hit)
            $display("reg_value_fwd trace: read r%0d -> 0x%h", bus.ReadRegister1, bus.Output1);
    end
`endif
endmodule

// File: tb/tb_reg_value_fwd.sv
// Directed bench for reg_value_fwd: a full-width instance and a 2-bit-counter instance.
module tb_reg_value_fwd;
    logic        CLK;
    logic        RESET;
    logic        comment;
    logic [31:0] cnt_a;
    logic [1:0]  cnt_b;
    logic        hq_a, hq_b;
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          chk_on   = 0;

    // Spec-level model state
    logic [63:0] m_cnt_a, m_cnt_b;
    logic        m_hq;

    reg_value_fwd_if #(.DATA_W(32), .REG_W(5)) bus_a ();
    reg_value_fwd_if #(.DATA_W(32), .REG_W(5)) bus_b ();

    reg_value_fwd #(.DATA_W(32), .REG_W(5), .CNT_W(32)) dut_a (
        .CLK(CLK), .RESET(RESET), .comment(comment), .bus(bus_a.slave),
        .fwd_count(cnt_a), .fwd_hit_q(hq_a));

    reg_value_fwd #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut_b (
        .CLK(CLK), .RESET(RESET), .comment(1'b0), .bus(bus_b.slave),
        .fwd_count(cnt_b), .fwd_hit_q(hq_b));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit model_hit();
        return bus_a.Valid1stPri1 && (bus_a.ReadRegister1 != 5'd0)
            && (bus_a.WriteRegister1stPri1 == bus_a.ReadRegister1);
    endfunction

    function automatic logic [31:0] model_out();
        return model_hit() ? bus_a.WriteData1stPri1 : bus_a.RegisterData1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rd, input logic [31:0] rdat,
                         input logic [4:0] wr, input logic [31:0] wdat, input logic v);
        bus_a.ReadRegister1 = rd;  bus_a.RegisterData1 = rdat;
        bus_a.WriteRegister1stPri1 = wr; bus_a.WriteData1stPri1 = wdat;
        bus_a.Valid1stPri1 = v;
        bus_b.ReadRegister1 = rd;  bus_b.RegisterData1 = rdat;
        bus_b.WriteRegister1stPri1 = wr; bus_b.WriteData1stPri1 = wdat;
        bus_b.Valid1stPri1 = v;
    endtask

    // Counting model: one count per clocked hit, clamped at each instance's maximum
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_cnt_a = '0; m_cnt_b = '0; m_hq = 1'b0;
        end else begin
            m_hq = model_hit();
            if (m_hq) begin
                if (m_cnt_a < 64'hFFFF_FFFF) m_cnt_a = m_cnt_a + 1;
                if (m_cnt_b < 64'd3)         m_cnt_b = m_cnt_b + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (chk_on) begin
            chk("cyc_out_a",  64'(bus_a.Output1), 64'(model_out()));
            chk("cyc_hit_a",  64'(bus_a.fwd_hit), 64'(model_hit()));
            chk("cyc_out_b",  64'(bus_b.Output1), 64'(model_out()));
            chk("cyc_cnt_a",  64'(cnt_a), m_cnt_a);
            chk("cyc_cnt_b",  64'(cnt_b), m_cnt_b);
            chk("cyc_hq_a",   64'(hq_a), 64'(m_hq));
            chk("cyc_hq_b",   64'(hq_b), 64'(m_hq));
        end
    end

    initial begin
        RESET = 1'b0;
        comment = 1'b0;
        drive(5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cnt", 64'(cnt_a), 64'd0);
        chk("rst_hq",  64'(hq_a),  64'd0);
        @(negedge CLK); #1;
        RESET = 1'b1;
        chk_on = 1'b1;

        // 1: live match forwards the write data
        comment = 1'b1;
        drive(5'd5, 32'h1111_1111, 5'd5, 32'hDEAD_BEEF, 1'b1);
        #1;
        chk("t1_out", 64'(bus_a.Output1), 64'hDEAD_BEEF);
        chk("t1_hit", 64'(bus_a.fwd_hit), 64'd1);
        @(posedge CLK); #1;
        comment = 1'b0;
        chk("t1_cnt", 64'(cnt_a), 64'd1);
        chk("t1_hq",  64'(hq_a),  64'd1);

        // 2: same match, write not valid
        drive(5'd5, 32'h1111_1111, 5'd5, 32'hDEAD_BEEF, 1'b0);
        #1;
        chk("t2_out", 64'(bus_a.Output1), 64'h1111_1111);
        chk("t2_hit", 64'(bus_a.fwd_hit), 64'd0);
        @(posedge CLK); #1;
        chk("t2_cnt", 64'(cnt_a), 64'd1);
        chk("t2_hq",  64'(hq_a),  64'd0);

        // 3: register 0 never forwards, data passes through untouched
        drive(5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        #1;
        chk("t3_out", 64'(bus_a.Output1), 64'd0);
        chk("t3_hit", 64'(bus_a.fwd_hit), 64'd0);
        drive(5'd0, 32'h0000_00A5, 5'd0, 32'hFFFF_FFFF, 1'b1);
        #1;
        chk("t3_out_nz", 64'(bus_a.Output1), 64'hA5);
        @(posedge CLK); #1;
        chk("t3_cnt", 64'(cnt_a), 64'd1);

        // 4: index mismatch, then match appears with no clock edge
        drive(5'd7, 32'h0000_0077, 5'd8, 32'h0000_ABCD, 1'b1);
        #1;
        chk("t4_miss", 64'(bus_a.Output1), 64'h77);
        bus_a.WriteRegister1stPri1 = 5'd7;
        bus_b.WriteRegister1stPri1 = 5'd7;
        #1;
        chk("t4_hit_out", 64'(bus_a.Output1), 64'hABCD);
        chk("t4_hit",     64'(bus_a.fwd_hit), 64'd1);
        @(posedge CLK); #1;
        chk("t4_cnt", 64'(cnt_a), 64'd2);

        // 5: three hits, then asynchronous reset between edges
        drive(5'd9, 32'h0000_0001, 5'd9, 32'h0000_0099, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        chk("t5_cnt_pre", 64'(cnt_a), 64'd5);
        #2;
        RESET = 1'b0;
        #1;
        chk("t5_cnt_rst", 64'(cnt_a), 64'd0);
        chk("t5_hq_rst",  64'(hq_a),  64'd0);
        chk("t5_out_rst", 64'(bus_a.Output1), 64'h99);
        drive(5'd9, 32'h0000_1234, 5'd3, 32'h0000_0099, 1'b1);
        #1;
        chk("t5_out_rst2", 64'(bus_a.Output1), 64'h1234);
        @(posedge CLK); #1;
        chk("t5_cnt_hold", 64'(cnt_a), 64'd0);
        drive(5'd9, 32'h0000_1234, 5'd9, 32'h0000_0099, 1'b1);
        #2;
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("t5_cnt_resume", 64'(cnt_a), 64'd1);

        // 6: 2-bit counter saturates at 3
        @(negedge CLK); #1;
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
        drive(5'd31, 32'h0, 5'd31, 32'h5555_AAAA, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(posedge CLK); #1;
            chk("t6_sat_cnt", 64'(cnt_b), (i < 3) ? 64'(i) : 64'd3);
            chk("t6_full_cnt", 64'(cnt_a), 64'(i));
        end

        @(negedge CLK); #1;
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
